alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 108 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives ALU operands/selector, captures and masks result/flags, hands off under valid/ack.
module alu_cmd_sequencer #(
  parameter int N = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sweep,
  input  logic [3:0]   op_in,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [3:0]   alu_result,
  input  logic         alu_carry,
  input  logic         alu_cero,
  input  logic         alu_negativo,
  input  logic         alu_desbordamiento,
  output logic [3:0]   res_out,
  output logic [3:0]   flags_out,
  output logic [3:0]   op_out,
  output logic         res_valid,
  input  logic         res_ack,
  output logic         busy,
  output logic         err,
  output logic         sweep_done
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  state_t state;
  logic [3:0] cnt;
  logic sweep_q;
  logic illegal, shift_op, logic_op, nv_mask;
  logic [3:0] flags_nxt;
  always_comb begin
    illegal = op_in == 4'd0 || op_in > 4'd11;
    shift_op = alu_sel == 4'd9 || alu_sel == 4'd10;
    logic_op = alu_sel >= 4'd6 && alu_sel <= 4'd11;
    nv_mask = logic_op || alu_sel == 4'd1;
    flags_nxt = {alu_negativo & ~nv_mask, shift_op ? alu_result == 4'd0 : alu_cero,
                 alu_carry & ~logic_op, alu_desbordamiento & ~nv_mask};
  end
  // The counter runs SETTLE+1 edges so capture sees ALU outputs after SETTLE stable cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      sweep_q <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= 4'd1;
      res_out <= 4'd0;
      flags_out <= 4'd0;
      op_out <= 4'd0;
      res_valid <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          if (!sweep && illegal) begin
            res_out <= 4'd0;
            flags_out <= 4'd0;
            op_out <= op_in;
            err <= 1'b1;
            res_valid <= 1'b1;
            sweep_q <= 1'b0;
            state <= S_HOLD;
          end else begin
            alu_a <= a_in;
            alu_b <= b_in;
            alu_sel <= sweep ? 4'd1 : op_in;
            cnt <= SETTLE_LD;
            sweep_q <= sweep;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: if (cnt == 4'd0) begin
          res_out <= alu_result;
          flags_out <= flags_nxt;
          op_out <= alu_sel;
          err <= 1'b0;
          res_valid <= 1'b1;
          state <= S_HOLD;
        end else cnt <= cnt - 4'd1;
        S_HOLD: if (res_ack) begin
          res_valid <= 1'b0;
          if (sweep_q && op_out != 4'd11) begin
            alu_sel <= op_out + 4'd1;
            cnt <= SETTLE_LD;
            state <= S_SETTLE;
          end else begin
            sweep_done <= sweep_q;
            sweep_q <= 1'b0;
            busy <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vectors against a table-driven registered ALU stub, scoreboarded results.
module tb_alu_cmd_sequencer;
  logic clk, rst, start, sweep, res_ack;
  logic [3:0] op_in, a_in, b_in, alu_a, alu_b, alu_sel, alu_result;
  logic alu_carry, alu_cero, alu_negativo, alu_desbordamiento;
  logic [3:0] res_out, flags_out, op_out;
  logic res_valid, busy, err, sweep_done;
  int n_vec = 0, n_err = 0, sd_cnt = 0;
  logic rv_q = 1'b0;
  logic [12:0] sb[$];
  logic [7:0] tbl [16];
  logic [3:0] exp_res [12];
  logic [3:0] exp_flg [12];

  alu_cmd_sequencer #(.N(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sweep(sweep), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_cero(alu_cero),
    .alu_negativo(alu_negativo), .alu_desbordamiento(alu_desbordamiento),
    .res_out(res_out), .flags_out(flags_out), .op_out(op_out), .res_valid(res_valid),
    .res_ack(res_ack), .busy(busy), .err(err), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub: {res, c, z, n, v} per opcode, registered one edge after alu_sel.
  always @(posedge clk)
    {alu_result, alu_carry, alu_cero, alu_negativo, alu_desbordamiento} <= tbl[alu_sel];

  always @(negedge clk) begin
    if (res_valid && !rv_q) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got res=%h flags=%b op=%h err=%b, required no result", res_out, flags_out, op_out, err);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        if ({res_out, flags_out, op_out, err} !== e) begin
          n_err++;
          $display("FAIL sb_result: got res=%h flags=%b op=%h err=%b, required res=%h flags=%b op=%h err=%b",
                   res_out, flags_out, op_out, err, e[12:9], e[8:5], e[4:1], e[0]);
        end
      end
    end
    rv_q = res_valid;
    if (sweep_done) sd_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic wait_rv(input string nm);
    int k;
    for (k = 0; k < 12 && !res_valid; k++) tick();
    chk(nm, res_valid, 1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_alu_a"}, alu_a, 0);
    chk({nm, "_alu_b"}, alu_b, 0);
    chk({nm, "_alu_sel"}, alu_sel, 1);
    chk({nm, "_res"}, res_out, 0);
    chk({nm, "_flags"}, flags_out, 0);
    chk({nm, "_op"}, op_out, 0);
    chk({nm, "_valid"}, res_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_sweep_done"}, sweep_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rises[$];
    int done_c, sd0;
    logic prev;
    foreach (tbl[i]) tbl[i] = 8'h00;
    tbl[1] = 8'b0000_1111; tbl[2] = 8'b1111_0011; tbl[3] = 8'b0000_1100;
    tbl[4] = 8'b1000_0010; tbl[5] = 8'b0011_1001; tbl[6] = 8'b1000_1011;
    tbl[7] = 8'b0000_1111; tbl[8] = 8'b1110_1011; tbl[9] = 8'b0000_0010;
    tbl[10] = 8'b0101_1111; tbl[11] = 8'b0000_0100;
    exp_res = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h8, 4'h3, 4'h8, 4'h0, 4'hE, 4'h0, 4'h5, 4'h0};
    exp_flg = '{4'b0000, 4'b0110, 4'b1001, 4'b0110, 4'b1000, 4'b0011, 4'b0000,
                4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
    rst = 1'b1; start = 1'b0; sweep = 1'b0; res_ack = 1'b0;
    op_in = 4'd0; a_in = 4'd0; b_in = 4'd0;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();
    // single add
    start = 1'b1; op_in = 4'd1; a_in = 4'd7; b_in = 4'd9;
    sb.push_back({4'h0, 4'b0110, 4'd1, 1'b0});
    tick();
    start = 1'b0; a_in = 4'hF; b_in = 4'hF;
    chk("add_alu_a", alu_a, 7);
    chk("add_alu_b", alu_b, 9);
    chk("add_alu_sel", alu_sel, 1);
    chk("add_busy", busy, 1);
    chk("add_valid_t0", res_valid, 0);
    tick();
    chk("add_valid_t1", res_valid, 0);
    tick();
    chk("add_valid_t2", res_valid, 1);
    // hold without ack
    repeat (5) begin
      tick();
      chk("hold_res", res_out, 0);
      chk("hold_flags", flags_out, 4'b0110);
      chk("hold_valid", res_valid, 1);
    end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    chk("ack_valid", res_valid, 0);
    chk("ack_busy", busy, 0);
    // illegal opcode then legal AND-type op
    start = 1'b1; op_in = 4'd12;
    sb.push_back({4'h0, 4'b0000, 4'd12, 1'b1});
    tick();
    start = 1'b0;
    chk("ill_valid", res_valid, 1);
    chk("ill_err", err, 1);
    chk("ill_alu_sel", alu_sel, 1);
    chk("ill_res", res_out, 0);
    chk("ill_flags", flags_out, 0);
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    chk("ill_busy", busy, 0);
    start = 1'b1; op_in = 4'd6; a_in = 4'hC; b_in = 4'hA;
    sb.push_back({4'h8, 4'b0000, 4'd6, 1'b0});
    tick();
    start = 1'b0;
    chk("op6_alu_a", alu_a, 4'hC);
    chk("op6_alu_b", alu_b, 4'hA);
    chk("op6_alu_sel", alu_sel, 6);
    tick(); tick();
    chk("op6_valid", res_valid, 1);
    chk("op6_err", err, 0);
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    // full sweep with ack tied high
    for (int i = 1; i <= 11; i++) sb.push_back({exp_res[i], exp_flg[i], 4'(i), 1'b0});
    start = 1'b1; sweep = 1'b1; op_in = 4'd0; a_in = 4'd3; b_in = 4'd2; res_ack = 1'b1;
    tick();
    start = 1'b0; sweep = 1'b0;
    chk("sweep_alu_a", alu_a, 3);
    chk("sweep_alu_b", alu_b, 2);
    chk("sweep_alu_sel", alu_sel, 1);
    prev = 1'b0; done_c = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (res_valid && !prev) rises.push_back(c);
      prev = res_valid;
      if (sweep_done) begin
        done_c = c;
        break;
      end
    end
    res_ack = 1'b0;
    chk("sweep_pulses", rises.size(), 11);
    for (int i = 1; i < rises.size(); i++) chk("sweep_spacing", rises[i] - rises[i-1], 3);
    chk("sweep_done_seen", done_c != 0, 1);
    if (rises.size() > 0) chk("sweep_done_time", done_c - rises[rises.size()-1], 1);
    repeat (3) tick();
    chk("sweep_done_count", sd_cnt, 1);
    chk("sweep_idle_busy", busy, 0);
    // reset mid-sweep at opcode 0101
    for (int i = 1; i <= 5; i++) sb.push_back({exp_res[i], exp_flg[i], 4'(i), 1'b0});
    start = 1'b1; sweep = 1'b1; a_in = 4'd3; b_in = 4'd2;
    tick();
    start = 1'b0; sweep = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_rv("abort_wait_valid");
      if (k < 5) begin
        res_ack = 1'b1; tick(); res_ack = 1'b0;
      end
    end
    chk("abort_op", op_out, 5);
    sd0 = sd_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("abort");
    repeat (40) tick();
    chk("abort_no_sweep_done", sd_cnt, sd0);
    chk("abort_idle_busy", busy, 0);
    // start and ack together in HOLD
    start = 1'b1; op_in = 4'd3; a_in = 4'd1; b_in = 4'd1;
    sb.push_back({4'h0, 4'b0110, 4'd3, 1'b0});
    tick();
    start = 1'b0;
    wait_rv("both_wait_valid");
    start = 1'b1; res_ack = 1'b1; op_in = 4'd2;
    tick();
    start = 1'b0; res_ack = 1'b0;
    chk("both_valid", res_valid, 0);
    chk("both_busy", busy, 0);
    tick();
    chk("both_busy_next", busy, 0);
    repeat (3) tick();
    chk("both_no_new_op", res_valid, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
